// File: rtl/main_cu.sv
// main_cu: block scheduler for the per-block compute units.
// Enumerates every output block (i, j) of an mu x mu block grid in raster
// order and hands each pair to the lowest-index free CU. It counts the
// completions and pulses o_Done once all mu*mu blocks have finished.
// Optional feature: define MAIN_CU_PERF_EN to enable the 32-bit run-length
// counter on o_Cycle_Count. Without it, o_Cycle_Count is tied to 0.
//
// Handshake (per CU c): o_Indexes_Ready[c] is an offer that holds, with
// stable indices, until the CU shows i_Indexes_Received[c]=1 together with
// i_Result_Ready[c]=0. That combination means the CU took the job and
// cleared its previous result. The CU then signals completion by raising
// i_Result_Ready[c]. Both CU signals are sticky on the CU side.
module main_cu #(
   parameter int NUM_CU      = 4,
   parameter int index_width = 8,
   parameter int max_mu_log  = 8
) (
   input  logic                          i_Clock,
   input  logic                          i_Reset,
   input  logic                          i_Start,
   input  logic [max_mu_log-1:0]         i_mu,
   output logic [max_mu_log-1:0]         o_mu,
   output logic [NUM_CU*index_width-1:0] o_Row_Index,
   output logic [NUM_CU*index_width-1:0] o_Column_Index,
   output logic [NUM_CU-1:0]             o_Indexes_Ready,
   input  logic [NUM_CU-1:0]             i_Indexes_Received,
   input  logic [NUM_CU-1:0]             i_Result_Ready,
   output logic                          o_Busy,
   output logic                          o_Done,
   output logic [31:0]                   o_Cycle_Count,
   output logic [1:0]                    o_Dbg_Top_State,
   output logic [2*NUM_CU-1:0]           o_Dbg_Slot_State
);

   // Job counters must hold mu*mu without truncation.
   localparam int CW = 2*max_mu_log + 1;

   typedef enum logic [1:0] {
      TOP_IDLE   = 2'd0,
      TOP_RUN    = 2'd1,
      TOP_FINISH = 2'd2
   } top_state_t;

   typedef enum logic [1:0] {
      SLOT_FREE    = 2'd0,
      SLOT_OFFER   = 2'd1,
      SLOT_RUNNING = 2'd2
   } slot_state_t;

   top_state_t             top_q;
   slot_state_t            slot_q     [NUM_CU];
   logic [index_width-1:0] slot_row_q [NUM_CU];
   logic [index_width-1:0] slot_col_q [NUM_CU];
   logic [NUM_CU-1:0]      rdy_q;
   logic [max_mu_log-1:0]  mu_q;
   logic [index_width-1:0] row_q;
   logic [index_width-1:0] col_q;
   logic [CW-1:0]          issued_q;
   logic [CW-1:0]          completed_q;
   logic [CW-1:0]          completed_d;
   logic [CW-1:0]          mu_sq;
   logic [CW-1:0]          done_cnt;
   logic [NUM_CU-1:0]      grant;
   logic                   any_free;
   logic                   dispatch_en;
   logic                   col_wrap;
   logic                   busy_q;
   logic                   done_q;

   assign mu_sq       = CW'(mu_q) * CW'(mu_q);
   assign col_wrap    = (col_q == (index_width'(mu_q) - index_width'(1)));
   assign dispatch_en = (top_q == TOP_RUN) && (issued_q < mu_sq) && any_free;

   // Pick the lowest-index FREE slot as the dispatch target (one-hot).
   always_comb begin
      grant    = '0;
      any_free = 1'b0;
      for (int c = 0; c < NUM_CU; c++) begin
         if (!any_free && slot_q[c] == SLOT_FREE) begin
            grant[c] = 1'b1;
            any_free = 1'b1;
         end
      end
   end

   // Count the slots that complete this cycle. Only RUNNING slots count.
   always_comb begin
      done_cnt = '0;
      for (int c = 0; c < NUM_CU; c++) begin
         if (slot_q[c] == SLOT_RUNNING && i_Result_Ready[c]) begin
            done_cnt = done_cnt + CW'(1);
         end
      end
      completed_d = completed_q + done_cnt;
   end

   // Top FSM, job pointer and per-CU slot FSMs, all with registered outputs.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         top_q       <= TOP_IDLE;
         mu_q        <= '0;
         row_q       <= '0;
         col_q       <= '0;
         issued_q    <= '0;
         completed_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rdy_q       <= '0;
         for (int c = 0; c < NUM_CU; c++) begin
            slot_q[c]     <= SLOT_FREE;
            slot_row_q[c] <= '0;
            slot_col_q[c] <= '0;
         end
      end else begin
         case (top_q)
            TOP_IDLE: begin
               if (i_Start) begin
                  mu_q        <= i_mu;
                  row_q       <= '0;
                  col_q       <= '0;
                  issued_q    <= '0;
                  completed_q <= '0;
                  busy_q      <= 1'b1;
                  top_q       <= (i_mu == '0) ? TOP_FINISH : TOP_RUN;
               end
            end
            TOP_RUN: begin
               if (dispatch_en) begin
                  issued_q <= issued_q + CW'(1);
                  if (col_wrap) begin
                     col_q <= '0;
                     row_q <= row_q + index_width'(1);
                  end else begin
                     col_q <= col_q + index_width'(1);
                  end
               end
               completed_q <= completed_d;
               // The last completion drops Busy and raises Done on the same edge.
               if (completed_d == mu_sq) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  top_q  <= TOP_FINISH;
               end
            end
            TOP_FINISH: begin
               // If Done is already up, we came from RUN. Otherwise this is
               // the mu=0 path, which raises Done here for one cycle.
               if (done_q) begin
                  done_q <= 1'b0;
                  top_q  <= TOP_IDLE;
               end else begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            default: top_q <= TOP_IDLE;
         endcase

         for (int c = 0; c < NUM_CU; c++) begin
            case (slot_q[c])
               SLOT_FREE: begin
                  if (dispatch_en && grant[c]) begin
                     slot_row_q[c] <= row_q;
                     slot_col_q[c] <= col_q;
                     rdy_q[c]      <= 1'b1;
                     slot_q[c]     <= SLOT_OFFER;
                  end
               end
               SLOT_OFFER: begin
                  // A stale Result_Ready means the CU has not yet taken the new job.
                  if (i_Indexes_Received[c] && !i_Result_Ready[c]) begin
                     rdy_q[c]  <= 1'b0;
                     slot_q[c] <= SLOT_RUNNING;
                  end
               end
               SLOT_RUNNING: begin
                  if (i_Result_Ready[c]) begin
                     slot_q[c] <= SLOT_FREE;
                  end
               end
               default: slot_q[c] <= SLOT_FREE;
            endcase
         end
      end
   end

   for (genvar c = 0; c < NUM_CU; c++) begin : g_pack
      assign o_Row_Index[c*index_width +: index_width]    = slot_row_q[c];
      assign o_Column_Index[c*index_width +: index_width] = slot_col_q[c];
      assign o_Dbg_Slot_State[2*c +: 2]                   = slot_q[c];
   end

   assign o_mu            = mu_q;
   assign o_Indexes_Ready = rdy_q;
   assign o_Busy          = busy_q;
   assign o_Done          = done_q;
   assign o_Dbg_Top_State = top_q;

`ifdef MAIN_CU_PERF_EN
   logic [31:0] cycle_q;

   // Run length: clears on accepted start, counts busy cycles, saturates.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         cycle_q <= '0;
      end else if (top_q == TOP_IDLE && i_Start) begin
         cycle_q <= '0;
      end else if (busy_q && cycle_q != 32'hFFFF_FFFF) begin
         cycle_q <= cycle_q + 32'd1;
      end
   end

   assign o_Cycle_Count = cycle_q;
`else
   assign o_Cycle_Count = 32'd0;
`endif

endmodule

// File: tb/tb_main_cu.sv
// tb_main_cu: self-checking bench for main_cu with behavioural CU models.
// The expected job order is the raster list of (i, j) pairs. Expected
// Done/Busy timing and run length come from the model's own completion
// count.
module tb_main_cu;
   localparam int NUM_CU = 4;
   localparam int IW     = 8;
   localparam int MW     = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [MW-1:0]        mu_in;
   logic [NUM_CU-1:0]    recv;
   logic [NUM_CU-1:0]    res;
   logic [MW-1:0]        mu_out;
   logic [NUM_CU*IW-1:0] row_out;
   logic [NUM_CU*IW-1:0] col_out;
   logic [NUM_CU-1:0]    rdy;
   logic                 busy;
   logic                 done;
   logic [31:0]          cyc_cnt;
   logic [1:0]           dbg_top;
   logic [2*NUM_CU-1:0]  dbg_slot;

   int vectors = 0;
   int errors  = 0;

   // CU model state: phase 0 idle, 1 waiting to acknowledge, 2 computing.
   int            ack_dly [NUM_CU];
   int            run_dly [NUM_CU];
   int            cnt     [NUM_CU];
   int            ph      [NUM_CU];
   logic [IW-1:0] job_row [NUM_CU];
   logic [IW-1:0] job_col [NUM_CU];

   logic [2*IW-1:0] exp_q[$];
   int              offer_cu[$];
   int              offer_cyc[$];
   int              completions;
   int              cur_cyc;
   int              busy_cycles;

   main_cu #(.NUM_CU(NUM_CU), .index_width(IW), .max_mu_log(MW)) dut (
      .i_Clock            (clk),
      .i_Reset            (rst),
      .i_Start            (start),
      .i_mu               (mu_in),
      .o_mu               (mu_out),
      .o_Row_Index        (row_out),
      .o_Column_Index     (col_out),
      .o_Indexes_Ready    (rdy),
      .i_Indexes_Received (recv),
      .i_Result_Ready     (res),
      .o_Busy             (busy),
      .o_Done             (done),
      .o_Cycle_Count      (cyc_cnt),
      .o_Dbg_Top_State    (dbg_top),
      .o_Dbg_Slot_State   (dbg_slot)
   );

   always #5 clk = ~clk;

   task automatic set_delays(input int a0, input int r0, input int a, input int r);
      for (int c = 0; c < NUM_CU; c++) begin
         ack_dly[c] = (c == 0) ? a0 : a;
         run_dly[c] = (c == 0) ? r0 : r;
      end
   endtask

   task automatic cu_reset_model();
      for (int c = 0; c < NUM_CU; c++) begin
         ph[c]  = 0;
         cnt[c] = 0;
      end
      recv = '0;
      res  = '0;
   endtask

   // One sample of all CU models, called #1 after a rising edge.
   task automatic cu_step();
      logic [IW-1:0]   r;
      logic [IW-1:0]   cl;
      logic [2*IW-1:0] e;
      for (int c = 0; c < NUM_CU; c++) begin
         r  = row_out[c*IW +: IW];
         cl = col_out[c*IW +: IW];
         if (ph[c] == 1) begin
            vectors++;
            if (rdy[c] !== 1'b1 || r !== job_row[c] || cl !== job_col[c]) begin
               errors++;
               $display("FAIL offer_hold cu%0d: ready=%b idx=(%0d,%0d), required ready=1 idx=(%0d,%0d)",
                        c, rdy[c], r, cl, job_row[c], job_col[c]);
            end
            if (cnt[c] == 0) begin
               recv[c] = 1'b1;
               res[c]  = 1'b0;
               cnt[c]  = run_dly[c];
               ph[c]   = 2;
            end else begin
               cnt[c]--;
            end
         end else if (ph[c] == 2) begin
            vectors++;
            if (rdy[c] !== 1'b0 || r !== job_row[c] || cl !== job_col[c]) begin
               errors++;
               $display("FAIL run_hold cu%0d: ready=%b idx=(%0d,%0d), required ready=0 idx=(%0d,%0d)",
                        c, rdy[c], r, cl, job_row[c], job_col[c]);
            end
            if (cnt[c] == 0) begin
               res[c] = 1'b1;
               completions++;
               ph[c] = 0;
            end else begin
               cnt[c]--;
            end
         end else if (rdy[c] === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_offer cu%0d: offered (%0d,%0d), required no offer", c, r, cl);
            end else begin
               e = exp_q.pop_front();
               if ({r, cl} !== e) begin
                  errors++;
                  $display("FAIL job_order cu%0d: got (%0d,%0d), required (%0d,%0d)",
                           c, r, cl, e[2*IW-1:IW], e[IW-1:0]);
               end
            end
            job_row[c] = r;
            job_col[c] = cl;
            offer_cu.push_back(c);
            offer_cyc.push_back(cur_cyc);
            if (ack_dly[c] == 0) begin
               recv[c] = 1'b1;
               res[c]  = 1'b0;
               cnt[c]  = run_dly[c];
               ph[c]   = 2;
            end else begin
               cnt[c] = ack_dly[c] - 1;
               ph[c]  = 1;
            end
         end
      end
   endtask

   // Build the raster job list and pulse start. Leaves us #1 after the start edge.
   task automatic start_product(input logic [MW-1:0] mu);
      exp_q.delete();
      offer_cu.delete();
      offer_cyc.delete();
      completions = 0;
      busy_cycles = 0;
      for (int i = 0; i < int'(mu); i++) begin
         for (int j = 0; j < int'(mu); j++) begin
            exp_q.push_back({IW'(i), IW'(j)});
         end
      end
      @(negedge clk);
      start = 1'b1;
      mu_in = mu;
      @(posedge clk);
      #1;
      start = 1'b0;
      mu_in = MW'($urandom_range(0, 255));
      vectors++;
      if (mu_out !== mu) begin
         errors++;
         $display("FAIL mu_capture: got %0d, required %0d", mu_out, mu);
      end
   endtask

   task automatic run_product(input logic [MW-1:0] mu, input int budget);
      int          total;
      bit          exp_now;
      bit          exp_next;
      bit          finished;
      logic [31:0] exp_cc;
      total = int'(mu) * int'(mu);
      start_product(mu);
      exp_next = 1'b0;
      finished = 1'b0;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         cur_cyc  = cyc;
         exp_now  = exp_next;
         exp_next = 1'b0;
         vectors++;
         if (done !== exp_now) begin
            errors++;
            $display("FAIL done cyc%0d mu%0d: got %b, required %b", cyc, mu, done, exp_now);
         end
         vectors++;
         if (busy !== !exp_now) begin
            errors++;
            $display("FAIL busy cyc%0d mu%0d: got %b, required %b", cyc, mu, busy, !exp_now);
         end
         if (exp_now) begin
            finished = 1'b1;
            vectors++;
            if (mu_out !== mu) begin
               errors++;
               $display("FAIL mu_hold: got %0d, required %0d", mu_out, mu);
            end
         end else begin
            busy_cycles++;
            cu_step();
            start = ($urandom_range(0, 7) == 0);
            if (total == 0 && cyc == 0) exp_next = 1'b1;
            else if (total > 0 && completions == total) exp_next = 1'b1;
         end
      end
      start = 1'b0;
      vectors++;
      if (!finished) begin
         errors++;
         $display("FAIL timeout mu%0d: done=0 after %0d cycles, required done pulse", mu, budget);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL unissued mu%0d: %0d jobs left, required 0", mu, exp_q.size());
      end
`ifdef MAIN_CU_PERF_EN
      exp_cc = 32'(busy_cycles);
`else
      exp_cc = 32'd0;
`endif
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0 || rdy !== '0) begin
            errors++;
            $display("FAIL after_done mu%0d: done=%b busy=%b ready=%b, required 0 0 0", mu, done, busy, rdy);
         end
         vectors++;
         if (cyc_cnt !== exp_cc) begin
            errors++;
            $display("FAIL cycle_count mu%0d: got %0d, required %0d", mu, cyc_cnt, exp_cc);
         end
      end
   endtask

   task automatic check_all_zero(input string name);
      vectors++;
      if (mu_out !== '0 || row_out !== '0 || col_out !== '0 || rdy !== '0 ||
          busy !== 1'b0 || done !== 1'b0 || cyc_cnt !== '0 || dbg_top !== '0 || dbg_slot !== '0) begin
         errors++;
         $display("FAIL %s: mu=%0d row=%h col=%h rdy=%b busy=%b done=%b cc=%0d, required all 0",
                  name, mu_out, row_out, col_out, rdy, busy, done, cyc_cnt);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      set_delays(1, 9, 1, 9);
      run_product(8'd2, 200);
      vectors++;
      if (offer_cu.size() != 4) begin
         errors++;
         $display("FAIL basic_offers: got %0d offers, required 4", offer_cu.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            vectors++;
            if (offer_cu[k] != k || offer_cyc[k] != k + 1) begin
               errors++;
               $display("FAIL basic_dispatch job%0d: cu%0d at cyc%0d, required cu%0d at cyc%0d",
                        k, offer_cu[k], offer_cyc[k], k, k + 1);
            end
         end
      end
   endtask

   task automatic test_mixed_speed();
      set_delays(0, 0, 2, 25);
      run_product(8'd3, 400);
   endtask

   task automatic test_sticky();
      set_delays(3, 2, 3, 15);
      run_product(8'd3, 400);
   endtask

   task automatic test_mu_zero();
      set_delays(0, 3, 0, 3);
      run_product(8'd0, 20);
   endtask

   task automatic test_random();
      for (int it = 0; it < 5; it++) begin
         for (int c = 0; c < NUM_CU; c++) begin
            ack_dly[c] = $urandom_range(0, 3);
            run_dly[c] = $urandom_range(0, 12);
         end
         run_product(MW'($urandom_range(1, 4)), 2000);
      end
   endtask

   task automatic test_perf();
      set_delays(0, 19, 0, 19);
      run_product(8'd1, 100);
   endtask

   task automatic test_reset_mid_run();
      set_delays(0, 40, 0, 40);
      start_product(8'd2);
      for (int cyc = 0; cyc < 20 && offer_cu.size() < 3; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         cur_cyc = cyc;
         cu_step();
      end
      vectors++;
      if (offer_cu.size() != 3) begin
         errors++;
         $display("FAIL midrun_offers: got %0d offers, required 3", offer_cu.size());
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_all_zero("midrun_reset");
      @(negedge clk);
      rst = 1'b0;
      cu_reset_model();
      set_delays(1, 5, 1, 5);
      run_product(8'd1, 100);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      mu_in = '0;
      cu_reset_model();
      set_delays(0, 0, 0, 0);
      test_reset();
      test_basic();
      test_mixed_speed();
      test_sticky();
      test_mu_zero();
      test_random();
      test_perf();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
